// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (sll/srl/sra/rol); `define PIPELINED_SHIFTER_CARRY_OUT_EN adds carry_o.
// Latency STAGES cycles, one beat per cycle; a stalled output freezes every stage (in_ready_o low).
module pipelined_shifter #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int SHW    = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [1:0]       op_i,
   input  logic [SHW-1:0]   shamt_i,
   input  logic [WIDTH-1:0] src_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             busy_o
`ifdef PIPELINED_SHIFTER_CARRY_OUT_EN
   ,
   output logic             carry_o
`endif
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   logic              w_adv;
   logic [STAGES-1:0] w_vld_vec;

   assign w_adv      = !out_valid_o || out_ready_i;
   assign in_ready_o = w_adv;
   assign busy_o     = |w_vld_vec;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic [WIDTH-1:0] w_src;
      logic [WIDTH-1:0] w_dat;
      logic [SHW-1:0]   w_sh;
      logic [1:0]       w_op;
      logic             w_sign;
      logic             w_vld;
      logic [WIDTH-1:0] r_dat;
      logic             r_vld;
`ifdef PIPELINED_SHIFTER_CARRY_OUT_EN
      logic             w_cy_in;
      logic             w_cy;
      logic             r_cy;
`endif

      if (s == 0) begin : g_head
         assign w_src  = src_i;
         assign w_sh   = shamt_i;
         assign w_op   = op_i;
         assign w_sign = src_i[WIDTH-1];
         assign w_vld  = in_valid_i;
`ifdef PIPELINED_SHIFTER_CARRY_OUT_EN
         assign w_cy_in = 1'b0;
`endif
      end else begin : g_body
         assign w_src  = g_stage[s-1].r_dat;
         assign w_sh   = g_stage[s-1].g_ctl.r_sh;
         assign w_op   = g_stage[s-1].g_ctl.r_op;
         assign w_sign = g_stage[s-1].g_ctl.r_sign;
         assign w_vld  = g_stage[s-1].r_vld;
`ifdef PIPELINED_SHIFTER_CARRY_OUT_EN
         assign w_cy_in = g_stage[s-1].r_cy;
`endif
      end

      // Only the levels mapped to this stage act; the carry tracks the last bit pushed out.
      always_comb begin
         logic [2*WIDTH-1:0] w_wide;
         w_wide = '0;
         w_dat  = w_src;
`ifdef PIPELINED_SHIFTER_CARRY_OUT_EN
         w_cy   = w_cy_in;
`endif
         for (int i = 0; i < SHW; i++) begin
            if ((((i * STAGES) / SHW) == s) && w_sh[i]) begin
               case (w_op)
                  OP_SLL: begin
`ifdef PIPELINED_SHIFTER_CARRY_OUT_EN
                     w_cy  = w_dat[WIDTH-(1<<i)];
`endif
                     w_dat = w_dat << (1 << i);
                  end
                  OP_SRL: begin
`ifdef PIPELINED_SHIFTER_CARRY_OUT_EN
                     w_cy  = w_dat[(1<<i)-1];
`endif
                     w_dat = w_dat >> (1 << i);
                  end
                  OP_SRA: begin
`ifdef PIPELINED_SHIFTER_CARRY_OUT_EN
                     w_cy   = w_dat[(1<<i)-1];
`endif
                     w_wide = {{WIDTH{w_sign}}, w_dat} >> (1 << i);
                     w_dat  = w_wide[WIDTH-1:0];
                  end
                  default: begin
                     w_wide = {w_dat, w_dat} << (1 << i);
                     w_dat  = w_wide[2*WIDTH-1:WIDTH];
`ifdef PIPELINED_SHIFTER_CARRY_OUT_EN
                     w_cy   = w_dat[0];
`endif
                  end
               endcase
            end
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_vld <= 1'b0;
            r_dat <= '0;
`ifdef PIPELINED_SHIFTER_CARRY_OUT_EN
            r_cy  <= 1'b0;
`endif
         end else if (w_adv) begin
            r_vld <= w_vld;
            r_dat <= w_dat;
`ifdef PIPELINED_SHIFTER_CARRY_OUT_EN
            r_cy  <= w_cy;
`endif
         end
      end

      // The final stage has no downstream levels, so it keeps no control fields.
      if (s < STAGES-1) begin : g_ctl
         logic [SHW-1:0] r_sh;
         logic [1:0]     r_op;
         logic           r_sign;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_sh   <= '0;
               r_op   <= '0;
               r_sign <= 1'b0;
            end else if (w_adv) begin
               r_sh   <= w_sh;
               r_op   <= w_op;
               r_sign <= w_sign;
            end
         end
      end

      assign w_vld_vec[s] = r_vld;
   end

   assign out_valid_o = g_stage[STAGES-1].r_vld;
   assign result_o    = g_stage[STAGES-1].r_dat;
`ifdef PIPELINED_SHIFTER_CARRY_OUT_EN
   assign carry_o     = g_stage[STAGES-1].r_cy;
`endif

endmodule
